cache_refill_unit: RTL and testbench
====================================

# cache_refill_unit

Memory-side refill and writeback engine sitting directly downstream of `cache_set`. On a miss it optionally writes back the dirty victim line, then fetches the missing 128-bit line as four 32-bit beats over a simple req/ack memory bus. It presents the assembled line on `cs_ldata_in` with a one-cycle `cs_load_en`/`begin_load` strobe.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `BEAT_W`, 32, memory data beat width.
- `LINE_BYTES`, 16, cache line size in bytes; beats per line = `LINE_BYTES*8/BEAT_W` (4).

Ports (`clk` is the single clock; `rst` is synchronous and active-low):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-low reset.
- `miss_req_in`  in  1  miss request from the cache; held until `done_out`.
- `miss_addr_in`  in  32  missing address; bits [3:0] ignored.
- `miss_dirty_in`  in  1  victim line is dirty.
- `wb_addr_in`  in  32  victim line address; bits [3:0] ignored.
- `wb_data_in`  in  128  victim line from `cs_wbdata_out`.
- `ldata_out`  out  128  assembled line to `cs_ldata_in`.
- `load_en_out`  out  1  strobe to `cs_load_en`.
- `begin_load_out`  out  1  strobe to `begin_load`.
- `busy_out`  out  1  high in any state other than IDLE.
- `done_out`  out  1  one-cycle completion pulse.
- `mem_req_out`  out  1  memory beat request.
- `mem_we_out`  out  1  1 = write beat, 0 = read beat.
- `mem_addr_out`  out  32  beat address.
- `mem_wdata_out`  out  32  write beat data.
- `mem_ack_in`  in  1  beat accepted or returned this cycle.
- `mem_rdata_in`  in  32  read beat data, valid when `mem_ack_in` is high.

## Operation
- States and transitions:
  - IDLE → WB if `miss_req_in & miss_dirty_in`.
  - IDLE → FILL if `miss_req_in & ~miss_dirty_in`.
  - WB → FILL after the 4th ack.
  - FILL → LOAD after the 4th ack.
  - LOAD → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Addresses and data are latched at acceptance in IDLE. Later changes to `miss_*` and `wb_*` are ignored.
- Beat `n` (0..3) uses address `{addr[31:4], 4'b0} + 4*n`. Beat n maps to line bits `[32n+31:32n]` (little-endian; beat 0 = bytes 3:0).
- WB: `mem_we_out=1`; `mem_wdata_out` is the latched victim beat n.
- FILL: `mem_we_out=0`; on ack, `mem_rdata_in` is written into line buffer slot n.
- The beat counter is 2 bits. It advances only on ack, wraps 3→0 on the state change, and is cleared entering WB and FILL.
- LOAD: `load_en_out=1` and `begin_load_out=1` for exactly one cycle. `ldata_out` holds the full line, and stays stable until the next FILL begins.
- DONE: `done_out=1` for one cycle. The cache drops `miss_req_in` in response.

## Timing
- Reset values:
  - `mem_req_out`, `mem_we_out`, `load_en_out`, `begin_load_out`, `done_out`, `busy_out` = 0.
  - `mem_addr_out`, `mem_wdata_out`, `ldata_out` = 0.
  - State = IDLE, counter = 0.
- `miss_req_in` is sampled only in IDLE. `mem_req_out` rises the cycle after acceptance.
- `mem_req_out` stays high through every WB/FILL beat. `mem_addr_out`, `mem_we_out` and `mem_wdata_out` hold until the ack cycle and change on the next edge.
- `mem_ack_in` is ignored when `mem_req_out` is low, and in any state other than WB and FILL.
- Zero-wait memory (ack every cycle), clean miss accepted at edge 0:
  - FILL beats on cycles 1–4.
  - LOAD on cycle 5, DONE on cycle 6.
  - IDLE on cycle 7; a new request can be accepted at the end of cycle 7.
- Zero-wait memory, dirty miss: WB on cycles 1–4, FILL on 5–8, LOAD on 9, DONE on 10.
- Wait states stretch each beat indefinitely; there is no timeout.
- `rst` low at any edge, including mid-beat: the unit returns to reset values at that edge. A partially filled line is discarded and `load_en_out` is never issued for it.
- `miss_req_in` still high during the DONE cycle is not re-accepted. Acceptance requires IDLE.

## Configuration
- `CACHE_REFILL_WB_EN` defined:
  - WB state, victim latches and the write path exist.
  - Behaviour is as above.
- `CACHE_REFILL_WB_EN` undefined:
  - WB state, victim latches and the write path are removed.
  - `miss_dirty_in`, `wb_addr_in` and `wb_data_in` are ignored.
  - `mem_we_out` is tied to 0 and `mem_wdata_out` is tied to 0.
  - Every miss goes IDLE → FILL. This is the write-through cache build.

## Structure
- Shared package `cache_pkg` holds:
  - `CACHE_LINE_SIZE` (16), `CACHE_LINE_BIT_NUM` (128), `REFILL_BEATS` (4).
  - The state enum `refill_state_t` {IDLE, WB, FILL, LOAD, DONE}.
  - Line-aligned address helper constants.
- One sub-module: `refill_line_buf`, a 128-bit buffer with a 2-bit beat write index and write enable. It produces `ldata_out` and performs read-out of victim beats.

## Test plan
- Clean miss, zero-wait: `miss_addr_in=32'hfff11114`, rdata beats `0,32'h12345678,0,0`.
  - Expect addresses `fff11110/14/18/1c`.
  - `ldata_out=128'h00000000_00000000_12345678_00000000` with `load_en_out` on cycle 5 and `done_out` on cycle 6.
- Dirty miss: `wb_addr_in=32'hfff11110`, `wb_data_in=128'h...87654321_12345678_00000000` (words 3..0 = 0, 87654321, 12345678, 0); `miss_addr_in=32'haaaa0004`.
  - Expect four writes to `fff11110..1c` carrying words 0..3 (0, 12345678, 87654321, 0).
  - Then four reads from `aaaa0000..0c`; LOAD on cycle 9.
- Wait states: ack delayed 3 cycles per beat.
  - Address and we stay stable while waiting; exactly 4 beats are transferred; resulting line is correct.
- Reset mid-FILL: `rst` low after beat 1 ack.
  - Next edge: `mem_req_out=0`, `busy_out=0`; no `load_en_out` ever issued.
  - A fresh miss afterwards completes normally.
- Request held across DONE: `miss_req_in` held high.
  - No second transfer starts until `miss_req_in` is seen in IDLE; a spurious `mem_ack_in` in IDLE is ignored.
- Build without `CACHE_REFILL_WB_EN`: dirty miss.
  - No write beats; FILL starts on cycle 1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and state type for the cache refill path.
package cache_pkg;

    localparam int CACHE_LINE_SIZE    = 16;
    localparam int CACHE_LINE_BIT_NUM = CACHE_LINE_SIZE * 8;
    localparam int REFILL_BEATS       = 4;

    // Byte-offset bits inside a line and the mask that clears them.
    localparam int          LINE_OFFSET_W  = $clog2(CACHE_LINE_SIZE);
    localparam logic [31:0] LINE_ADDR_MASK = ~32'(CACHE_LINE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        FILL = 3'd2,
        LOAD = 3'd3,
        DONE = 3'd4
    } refill_state_t;

endpackage

// File: rtl/refill_line_buf.sv
// Line buffer for the refill engine: collects read beats into the line
// presented to the cache, and slices one beat out of a victim line.
module refill_line_buf #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [BEAT_W-1:0] wr_data,
    output logic [LINE_W-1:0] line_out,
    input  logic [LINE_W-1:0] rd_line_in,
    input  logic [1:0]        rd_idx,
    output logic [BEAT_W-1:0] rd_beat_out
);
    import cache_pkg::*;

    logic [LINE_W-1:0] line_q, line_d;

    // Merge the incoming beat into its slot; other slots keep their value.
    always_comb begin
        line_d = line_q;
        if (wr_en) begin
            line_d[int'(wr_idx)*BEAT_W +: BEAT_W] = wr_data;
        end
    end

    // Line storage with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_out    = line_q;
    assign rd_beat_out = rd_line_in[int'(rd_idx)*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cache_refill_unit.sv
// Refill / writeback engine between the cache set and a req/ack memory bus.
// Define CACHE_REFILL_WB_EN to build the dirty-victim writeback path; without
// it every miss is a plain four-beat fill (write-through cache build).
//
// state | meaning
// IDLE  | waiting for a miss request
// WB    | writing the latched victim line, one beat per ack
// FILL  | reading the missing line, one beat per ack
// LOAD  | one-cycle load strobe with the assembled line
// DONE  | one-cycle completion pulse
module cache_refill_unit #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req_in,
    input  logic [ADDR_W-1:0]     miss_addr_in,
    input  logic                  miss_dirty_in,
    input  logic [ADDR_W-1:0]     wb_addr_in,
    input  logic [LINE_BYTES*8-1:0] wb_data_in,
    output logic [LINE_BYTES*8-1:0] ldata_out,
    output logic                  load_en_out,
    output logic                  begin_load_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic [BEAT_W-1:0]     mem_wdata_out,
    input  logic                  mem_ack_in,
    input  logic [BEAT_W-1:0]     mem_rdata_in
);
    import cache_pkg::*;

    localparam int LINE_W    = LINE_BYTES * 8;
    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int BEAT_B    = BEAT_W / 8;
    localparam logic [1:0] LAST_BEAT = 2'(REFILL_BEATS - 1);

    refill_state_t     state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] fill_base_q, fill_base_d;
    logic              beat_ack;
    logic              buf_wr_en;
    logic [BEAT_W-1:0] vic_beat;
    logic [LINE_W-1:0] vic_line;
    logic [ADDR_W-1:0] beat_off;

    assign beat_off = ADDR_W'(cnt_q) * ADDR_W'(BEAT_B);
    assign beat_ack = mem_req_out & mem_ack_in;

`ifdef CACHE_REFILL_WB_EN
    logic [ADDR_W-1:0] wb_base_q, wb_base_d;
    logic [LINE_W-1:0] vic_q, vic_d;
    logic              unused_off;

    assign unused_off = ^{miss_addr_in[OFF_W-1:0], wb_addr_in[OFF_W-1:0]};
    assign vic_line   = vic_q;

    // Victim address and data, captured only when a dirty miss is accepted.
    always_comb begin
        wb_base_d = wb_base_q;
        vic_d     = vic_q;
        if (state_q == IDLE && miss_req_in && miss_dirty_in) begin
            wb_base_d = {wb_addr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
            vic_d     = wb_data_in;
        end
    end

    // Victim latches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_base_q <= '0;
            vic_q     <= '0;
        end else begin
            wb_base_q <= wb_base_d;
            vic_q     <= vic_d;
        end
    end
`else
    logic unused_wb;

    assign vic_line  = '0;
    assign unused_wb = ^{miss_addr_in[OFF_W-1:0], miss_dirty_in, wb_addr_in,
                         wb_data_in, vic_beat};
`endif

    // Next state, beat counter and fill address latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_base_d = fill_base_q;
        case (state_q)
            IDLE: begin
                if (miss_req_in) begin
                    fill_base_d = {miss_addr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
                    cnt_d       = '0;
`ifdef CACHE_REFILL_WB_EN
                    state_d     = miss_dirty_in ? WB : FILL;
`else
                    state_d     = FILL;
`endif
                end
            end
`ifdef CACHE_REFILL_WB_EN
            WB: begin
                if (beat_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = FILL;
                    end
                end
            end
`endif
            FILL: begin
                if (beat_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_base_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_base_q <= fill_base_d;
        end
    end

    // Bus and strobe outputs decoded from the registered state, so they are
    // glitch-free and already at their idle values while in reset.
    always_comb begin
        mem_req_out    = 1'b0;
        mem_we_out     = 1'b0;
        mem_addr_out   = '0;
        mem_wdata_out  = '0;
        load_en_out    = 1'b0;
        begin_load_out = 1'b0;
        done_out       = 1'b0;
        busy_out       = (state_q != IDLE);
        buf_wr_en      = 1'b0;
        case (state_q)
`ifdef CACHE_REFILL_WB_EN
            WB: begin
                mem_req_out   = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = wb_base_q + beat_off;
                mem_wdata_out = vic_beat;
            end
`endif
            FILL: begin
                mem_req_out  = 1'b1;
                mem_addr_out = fill_base_q + beat_off;
                buf_wr_en    = mem_ack_in;
            end
            LOAD: begin
                load_en_out    = 1'b1;
                begin_load_out = 1'b1;
            end
            DONE:    done_out = 1'b1;
            default: ;
        endcase
    end

    refill_line_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (buf_wr_en),
        .wr_idx      (cnt_q),
        .wr_data     (mem_rdata_in),
        .line_out    (ldata_out),
        .rd_line_in  (vic_line),
        .rd_idx      (cnt_q),
        .rd_beat_out (vic_beat)
    );

endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: table of miss scenarios driven
// against a memory responder, expected beats kept in a scoreboard queue.
module tb_cache_refill_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req_in;
    logic [31:0]  miss_addr_in;
    logic         miss_dirty_in;
    logic [31:0]  wb_addr_in;
    logic [127:0] wb_data_in;
    logic [127:0] ldata_out;
    logic         load_en_out;
    logic         begin_load_out;
    logic         busy_out;
    logic         done_out;
    logic         mem_req_out;
    logic         mem_we_out;
    logic [31:0]  mem_addr_out;
    logic [31:0]  mem_wdata_out;
    logic         mem_ack_in;
    logic [31:0]  mem_rdata_in;

    always #5 clk = ~clk;

    cache_refill_unit dut (
        .clk            (clk),
        .rst            (rst),
        .miss_req_in    (miss_req_in),
        .miss_addr_in   (miss_addr_in),
        .miss_dirty_in  (miss_dirty_in),
        .wb_addr_in     (wb_addr_in),
        .wb_data_in     (wb_data_in),
        .ldata_out      (ldata_out),
        .load_en_out    (load_en_out),
        .begin_load_out (begin_load_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .mem_req_out    (mem_req_out),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_wdata_out  (mem_wdata_out),
        .mem_ack_in     (mem_ack_in),
        .mem_rdata_in   (mem_rdata_in)
    );

`ifdef CACHE_REFILL_WB_EN
    localparam bit WB_BUILD = 1'b1;
`else
    localparam bit WB_BUILD = 1'b0;
`endif

    typedef struct {
        logic [31:0]       miss_addr;
        logic              dirty;
        logic [31:0]       wb_addr;
        logic [127:0]      wb_data;
        logic [3:0][31:0]  rdata;
        int                wait_n;
        bit                hold;
        logic [127:0]      exp_line;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    int           n_assert = 0;
    int           n_fail   = 0;
    beat_t        sb[$];
    logic [127:0] prev_line = '0;
    vec_t         vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ma, input logic d, input logic [31:0] wa,
                                input logic [127:0] wd, input logic [31:0] r0,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] r3, input int w, input bit h,
                                input logic [127:0] el);
        vec_t v;
        v.miss_addr = ma;
        v.dirty     = d;
        v.wb_addr   = wa;
        v.wb_data   = wd;
        v.rdata[0]  = r0;
        v.rdata[1]  = r1;
        v.rdata[2]  = r2;
        v.rdata[3]  = r3;
        v.wait_n    = w;
        v.hold      = h;
        v.exp_line  = el;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        miss_req_in = 1'b0;
        mem_ack_in  = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        sb.delete();
        prev_line = '0;
    endtask

    task automatic run_case(input vec_t v);
        beat_t b;
        int    cyc, load_cyc, done_cyc, n_load, wcnt, rd_i, nbeats, exp_load;
        bit    done_seen;
        logic [31:0] wb_base, fill_base;

        sb.delete();
        wb_base   = v.wb_addr & 32'hffff_fff0;
        fill_base = v.miss_addr & 32'hffff_fff0;
        if (WB_BUILD && v.dirty) begin
            for (int n = 0; n < 4; n++) begin
                b.addr = wb_base + 32'(4 * n);
                b.we   = 1'b1;
                b.data = v.wb_data[32*n +: 32];
                sb.push_back(b);
            end
        end
        for (int n = 0; n < 4; n++) begin
            b.addr = fill_base + 32'(4 * n);
            b.we   = 1'b0;
            b.data = '0;
            sb.push_back(b);
        end
        nbeats   = sb.size();
        exp_load = nbeats * (v.wait_n + 1) + 1;

        miss_req_in   = 1'b1;
        miss_addr_in  = v.miss_addr;
        miss_dirty_in = v.dirty;
        wb_addr_in    = v.wb_addr;
        wb_data_in    = v.wb_data;
        step();
        // Accepted at that edge; later changes must have no effect.
        miss_addr_in  = 32'hdead_beef;
        miss_dirty_in = ~v.dirty;
        wb_addr_in    = 32'h0bad_0bad;
        wb_data_in    = {4{32'h5a5a_a5a5}};

        cyc = 0; load_cyc = 0; done_cyc = 0; n_load = 0; wcnt = 0; rd_i = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 400) begin
            cyc++;
            mem_ack_in   = 1'b0;
            mem_rdata_in = 32'hbad0_bad0;
            if (cyc == 1) begin
                chk("busy_cycle1", busy_out, 1);
                chk("ldata_hold_cycle1", ldata_out, prev_line);
            end
            if (load_en_out) begin
                n_load++;
                load_cyc = cyc;
                chk("begin_load", begin_load_out, 1);
                chk("ldata_line", ldata_out, v.exp_line);
            end
            if (done_out) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (mem_req_out) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL extra_beat: got request at %h expected none", mem_addr_out);
                    mem_ack_in = 1'b1;
                end else begin
                    b = sb[0];
                    chk("beat_addr", mem_addr_out, b.addr);
                    chk("beat_we", mem_we_out, b.we);
                    if (b.we) chk("beat_wdata", mem_wdata_out, b.data);
                    if (wcnt == v.wait_n) begin
                        mem_ack_in = 1'b1;
                        wcnt = 0;
                        if (!b.we) begin
                            mem_rdata_in = v.rdata[rd_i];
                            rd_i++;
                        end
                        void'(sb.pop_front());
                    end else begin
                        wcnt++;
                    end
                end
            end
            if (!done_seen) step();
        end

        if (!done_seen) begin
            n_assert++;
            n_fail++;
            $display("FAIL timeout: got no done_out after %0d cycles expected done at %0d", cyc, exp_load + 1);
            do_reset();
            return;
        end

        chk("load_cycle", load_cyc, exp_load);
        chk("done_cycle", done_cyc, exp_load + 1);
        chk("load_count", n_load, 1);
        chk("beats_left", sb.size(), 0);

        if (v.hold) begin
            // Request still high and a stray ack during DONE.
            mem_ack_in = 1'b1;
            step();
            chk("held_idle_busy", busy_out, 0);
            chk("held_idle_req", mem_req_out, 0);
            miss_req_in = 1'b0;
            mem_ack_in  = 1'b1;
            step();
            chk("idle_ack_busy", busy_out, 0);
            chk("idle_ack_req", mem_req_out, 0);
            mem_ack_in = 1'b0;
        end else begin
            miss_req_in = 1'b0;
            mem_ack_in  = 1'b0;
            step();
            chk("post_done_busy", busy_out, 0);
        end
        chk("ldata_stable", ldata_out, v.exp_line);
        prev_line = v.exp_line;
    endtask

    initial begin
        bit seen_load;

        rst           = 1'b0;
        miss_req_in   = 1'b0;
        miss_addr_in  = '0;
        miss_dirty_in = 1'b0;
        wb_addr_in    = '0;
        wb_data_in    = '0;
        mem_ack_in    = 1'b0;
        mem_rdata_in  = '0;
        repeat (3) step();

        chk("rst_mem_req", mem_req_out, 0);
        chk("rst_mem_we", mem_we_out, 0);
        chk("rst_load_en", load_en_out, 0);
        chk("rst_begin_load", begin_load_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_mem_addr", mem_addr_out, 0);
        chk("rst_mem_wdata", mem_wdata_out, 0);
        chk("rst_ldata", ldata_out, 0);

        rst = 1'b1;
        step();

        vecs[0] = mk(32'hfff1_1114, 1'b0, 32'h0, 128'h0,
                     32'h0, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b0,
                     128'h00000000_00000000_12345678_00000000);
        vecs[1] = mk(32'haaaa_0004, 1'b1, 32'hfff1_1110,
                     128'h00000000_87654321_12345678_00000000,
                     32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0, 1'b0,
                     128'h44444444_33333333_22222222_11111111);
        vecs[2] = mk(32'h0000_123c, 1'b0, 32'h0, 128'h0,
                     32'ha0a0_a0a0, 32'hb1b1_b1b1, 32'hc2c2_c2c2, 32'hd3d3_d3d3, 3, 1'b0,
                     128'hd3d3d3d3_c2c2c2c2_b1b1b1b1_a0a0a0a0);
        vecs[3] = mk(32'h8000_0008, 1'b1, 32'h4000_00f4,
                     128'hcafef00d_0badc0de_feedface_deadbeef,
                     32'h0102_0304, 32'h0506_0708, 32'h090a_0b0c, 32'h0d0e_0f10, 2, 1'b0,
                     128'h0d0e0f10_090a0b0c_05060708_01020304);
        vecs[4] = mk(32'h5555_5550, 1'b0, 32'h0, 128'h0,
                     32'hffff_ffff, 32'h0, 32'hffff_ffff, 32'h1, 0, 1'b1,
                     128'h00000001_ffffffff_00000000_ffffffff);

        for (int i = 0; i < 5; i++) begin
            run_case(vecs[i]);
        end

        // Reset while the second beat of a fill has just been acked.
        miss_req_in   = 1'b1;
        miss_addr_in  = 32'h0000_0100;
        miss_dirty_in = 1'b0;
        step();
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h0000_0001;
        step();
        mem_rdata_in = 32'h0000_0002;
        step();
        chk("pre_rst_req", mem_req_out, 1);
        rst          = 1'b0;
        mem_rdata_in = 32'h0000_0003;
        step();
        chk("midrst_req", mem_req_out, 0);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_ldata", ldata_out, 0);
        chk("midrst_addr", mem_addr_out, 0);
        rst         = 1'b1;
        miss_req_in = 1'b0;
        mem_ack_in  = 1'b0;
        seen_load   = 1'b0;
        repeat (8) begin
            step();
            if (load_en_out) seen_load = 1'b1;
        end
        chk("no_load_after_rst", seen_load, 0);
        prev_line = '0;

        run_case(vecs[0]);
        run_case(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
